// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the instruction-cache refill engine.
// Holds the FSM state encoding, bus widths and the byte-lane decoder.
package icache_refill_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic        RstnEnable = 1'b0;

    // Bytes fetched per instruction; the counters run 0..4.
    localparam logic [2:0] InstBytes = 3'd4;

    typedef enum logic [1:0] {
        IRefIdle  = 2'd0,
        IRefRead  = 2'd1,
        IRefWrite = 2'd2
    } iref_state_t;

    // One-hot write enable for byte lane 0..3 of the assembled word.
    function automatic logic [3:0] lane_decode(input logic [1:0] lane);
        lane_decode = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/icache_refill.sv
// I-cache refill engine: reads a missing instruction byte by byte through
// the memory arbiter, assembles it little-endian and writes it to the cache.
// Ports:
//   clk, rst (async, active-low)
//   miss_valid/miss_addr/miss_ready : refill request from fetch
//   flush                           : abandon the refill in progress
//   mem_req/mem_a/mem_gnt/mem_din   : byte read port (1-cycle read latency)
//   fill_we/fill_addr/fill_inst     : one-cycle write into the cache
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_a,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_din,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [INST_W-1:0] fill_inst
);

    iref_state_t state_q;
    iref_state_t state_d;

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        issued_q;
    logic [2:0]        recvd_q;
    logic              pend_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] fill_addr_q;

    logic       accept;
    logic       issue;
    logic       capture;
    logic       last;
    logic [3:0] lane_we;

    // The low address bits select a byte inside the word and are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            state_q <= IRefIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        miss_ready = 1'b0;
        mem_req    = 1'b0;
        fill_we    = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        last       = 1'b0;
        unique case (state_q)
            IRefIdle: begin
                miss_ready = rst;
                if (miss_valid && rst && !flush) begin
                    accept  = 1'b1;
                    state_d = IRefRead;
                end
            end
            IRefRead: begin
                mem_req = (issued_q < InstBytes);
                issue   = mem_req && mem_gnt;
                // A flush discards the byte returning this cycle.
                capture = pend_q && !flush;
                last    = capture && (recvd_q == InstBytes - 3'd1);
                if (flush) begin
                    state_d = IRefIdle;
                end else if (last) begin
                    state_d = IRefWrite;
                end
            end
            IRefWrite: begin
                // The word is complete, so a flush here still writes it.
                fill_we = 1'b1;
                state_d = IRefIdle;
            end
            default: begin
                state_d = IRefIdle;
            end
        endcase
    end

    // base is word aligned, so base + 0..3 never carries out of the word.
    assign mem_a   = mem_req ? base_q + ADDR_W'(issued_q) : '0;
    assign lane_we = capture ? lane_decode(recvd_q[1:0]) : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            base_q      <= '0;
            issued_q    <= '0;
            recvd_q     <= '0;
            pend_q      <= 1'b0;
            inst_q      <= INST_W'(ZeroWord);
            fill_addr_q <= '0;
        end else begin
            if (accept) begin
                base_q   <= {miss_addr[ADDR_W-1:2], 2'b00};
                issued_q <= '0;
                recvd_q  <= '0;
                pend_q   <= 1'b0;
            end else if (state_q == IRefRead) begin
                if (flush) begin
                    issued_q <= '0;
                    recvd_q  <= '0;
                    pend_q   <= 1'b0;
                end else begin
                    pend_q <= issue;
                    if (issue) begin
                        issued_q <= issued_q + 3'd1;
                    end
                    if (capture) begin
                        recvd_q <= recvd_q + 3'd1;
                    end
                end
            end else begin
                pend_q <= 1'b0;
            end

            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    inst_q[8*i +: 8] <= mem_din;
                end
            end

            if (last) begin
                fill_addr_q <= base_q;
            end
        end
    end

    assign fill_addr = fill_addr_q;
    assign fill_inst = inst_q;

endmodule

// File: tb/tb_icache_refill.sv
// Randomized scoreboard bench for icache_refill: a sparse RAM model feeds
// the byte port; expected issues and fills are queued and popped by monitors.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_din = '0;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [31:0] fill_inst;

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
    } fill_t;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] exp_iss [$];
    fill_t       exp_fill [$];

    fill_t       mon_f;
    logic [31:0] mon_a;
    logic        iss_v = 1'b0;
    logic [31:0] iss_a = '0;

    icache_refill #(.ADDR_W(32), .INST_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .miss_valid(miss_valid),
        .miss_addr(miss_addr),
        .miss_ready(miss_ready),
        .flush(flush),
        .mem_req(mem_req),
        .mem_a(mem_a),
        .mem_gnt(mem_gnt),
        .mem_din(mem_din),
        .fill_we(fill_we),
        .fill_addr(fill_addr),
        .fill_inst(fill_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (!ram.exists(a)) ram[a] = 8'($urandom);
        return ram[a];
    endfunction

    function automatic bit gnt_at(input int gap, input int c);
        return !(c < 32 && gap[c]);
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    // Memory: a read issued in cycle c returns its byte during cycle c+1.
    always @(negedge clk) begin
        iss_v = mem_req && mem_gnt;
        iss_a = mem_a;
    end

    always @(posedge clk) begin
        #1;
        mem_din = iss_v ? rd(iss_a) : 8'($urandom);
    end

    // Issue monitor: every byte read must hit the next expected address.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
            if (exp_iss.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL issue_unexp: got read of %h want none", mem_a);
            end else begin
                mon_a = exp_iss.pop_front();
                chk("mem_a", mem_a, mon_a);
            end
        end
    end

    // Fill monitor: every cache write must match the next expected word.
    always @(negedge clk) begin
        if (fill_we === 1'b1) begin
            if (exp_fill.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL fill_unexp: got fill of %h want none", fill_addr);
            end else begin
                mon_f = exp_fill.pop_front();
                chk("fill_addr", fill_addr, mon_f.a);
                chk("fill_inst", fill_inst, mon_f.i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        flush      = 1'b0;
        miss_valid = 1'b0;
    endtask

    // One miss starting in the current cycle (cycle 0). gap bit c drops the
    // grant in cycle c; f is the flush cycle (-1 none, 0 together with miss).
    task automatic do_miss(input logic [31:0] a, input int gap, input int f);
        logic [31:0] b;
        fill_t       fe;
        int          n;
        int          g4;
        int          fillc;
        int          last;
        bit          acc;
        bit          ab;
        b  = a & ~32'h3;
        n  = 0;
        g4 = 0;
        for (int c = 1; c < 64 && g4 == 0; c++) begin
            if (gnt_at(gap, c)) begin
                n++;
                if (n == 4) g4 = c;
            end
        end
        fillc = g4 + 2;
        acc   = (f != 0);
        ab    = (f >= 1 && f < fillc);
        last  = !acc ? 1 : (ab ? f : fillc);

        miss_valid = 1'b1;
        miss_addr  = a;
        flush      = (f == 0);
        mem_gnt    = gnt_at(gap, 0);
        @(negedge clk);
        chk("ready_c0", miss_ready, 1);
        if (acc) begin
            for (int k = 0; k < 4; k++) exp_iss.push_back(b + k);
            if (!ab) begin
                fe.a = b;
                fe.i = {rd(b + 3), rd(b + 2), rd(b + 1), rd(b)};
                exp_fill.push_back(fe);
            end
        end

        for (int c = 1; c <= last; c++) begin
            step();
            miss_addr = $urandom;
            flush     = (c == f);
            mem_gnt   = gnt_at(gap, c);
            @(negedge clk);
            chk("mem_req", mem_req, acc && c <= g4);
            chk("fill_we", fill_we, acc && !ab && c == fillc);
            chk("miss_ready", miss_ready, !acc);
        end
        if (ab) begin
            #1;
            exp_iss.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int f;
        ram[32'h1004] = 8'h13;
        ram[32'h1005] = 8'h05;
        ram[32'h1006] = 8'h10;
        ram[32'h1007] = 8'h00;

        @(negedge clk);
        chk("rst_ready", miss_ready, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_we", fill_we, 0);
        chk("rst_faddr", fill_addr, 0);
        chk("rst_finst", fill_inst, 0);
        step();
        rst     = 1'b1;
        mem_gnt = 1'b1;

        // Basic refill, then held outputs after WRITE.
        do_miss(32'h0000_1006, 0, -1);
        step();
        @(negedge clk);
        chk("hold_inst", fill_inst, 32'h0010_0513);
        chk("hold_addr", fill_addr, 32'h0000_1004);

        // Grant gaps in cycles 2 and 3.
        step();
        do_miss(32'h0000_1006, 32'b1100, -1);

        // Flush mid-read, new miss right after.
        step();
        do_miss(32'h0000_1006, 0, 3);
        step();
        do_miss(32'h0000_2000, 0, -1);

        // Flush in WRITE, then flush together with a request.
        step();
        do_miss(32'h0000_1006, 0, 6);
        step();
        do_miss(32'h0000_1234, 0, 0);

        // Asynchronous reset during cycle 4 of a refill.
        step();
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3000;
        mem_gnt    = 1'b1;
        for (int k = 0; k < 4; k++) exp_iss.push_back(32'h3000 + k);
        for (int c = 1; c <= 4; c++) step();
        #1;
        rst = 1'b0;
        #1;
        chk("arst_ready", miss_ready, 0);
        chk("arst_req", mem_req, 0);
        chk("arst_mem_a", mem_a, 0);
        chk("arst_we", fill_we, 0);
        chk("arst_faddr", fill_addr, 0);
        chk("arst_finst", fill_inst, 0);
        exp_iss.delete();
        step();
        @(negedge clk);
        chk("arst_we2", fill_we, 0);
        step();
        rst = 1'b1;
        do_miss(32'h0000_4008, 0, -1);

        // Address wrap at the top of memory.
        step();
        do_miss(32'hFFFF_FFFD, 0, -1);
        step();
        @(negedge clk);
        chk("wrap_faddr", fill_addr, 32'hFFFF_FFFC);

        // Random misses, grant gaps and flushes.
        for (int t = 0; t < 60; t++) begin
            gap = int'($urandom & $urandom);
            case ($urandom_range(0, 7))
                0:       f = 0;
                1, 2:    f = int'($urandom_range(1, 10));
                default: f = -1;
            endcase
            step();
            do_miss($urandom, gap, f);
        end

        step();
        step();
        @(negedge clk);
        chk("drain_fill", exp_fill.size(), 0);
        chk("drain_iss", exp_iss.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Refill engine on the write side of the instruction cache. On a fetch miss it reads the 32-bit instruction from the byte-wide unified memory port through the memory arbiter and assembles it little-endian. It then issues one write (`we`, address, instruction) into the cache so the next lookup hits. It sits between the fetch stage, the memory arbiter and the cache fill port.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `INST_W`, 32: instruction width; fixed at 4 bytes.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `miss_valid`  in  1  fetch requests a refill of `miss_addr`.
- `miss_addr`  in  ADDR_W  missing PC; bits [1:0] ignored.
- `miss_ready`  out  1  high only in IDLE with `rst` high.
- `flush`  in  1  abandon the current refill (redirect or mispredict).
- `mem_req`  out  1  requests the memory port.
- `mem_a`  out  ADDR_W  byte address; valid while `mem_req`.
- `mem_gnt`  in  1  arbiter grant; a byte read issues in a cycle where `mem_req & mem_gnt`.
- `mem_din`  in  8  read data; fixed latency of 1 cycle after issue.
- `fill_we`  out  1  one-cycle write strobe to the cache `we`.
- `fill_addr`  out  ADDR_W  word-aligned write address.
- `fill_inst`  out  INST_W  assembled instruction.

## Operation
- States are IDLE, READ and WRITE.
- **IDLE.**
  - `miss_valid & miss_ready & ~flush` latches `base = {miss_addr[31:2], 2'b00}`.
  - It also clears `issued` and `recvd` (both 3-bit) and moves to READ.
- **READ, issue side.**
  - `mem_req = (issued < 4)` and `mem_a = base + issued`.
  - Each issue increments `issued` and sets `pend`; otherwise `pend` is cleared.
- **READ, receive side.**
  - When `pend` is set, `mem_din` is written to byte lane `recvd` of `fill_inst` (byte 0 to [7:0], byte 3 to [31:24]), then `recvd` increments.
  - When the 4th byte is captured, the state moves to WRITE.
- **Grant gaps.** A dropped `mem_gnt` stalls issue only. A byte already in flight is still captured on the following cycle.
- **WRITE.** `fill_we = 1` and `fill_addr = base` for exactly one cycle, then the state returns to IDLE.
- **Flush in READ.**
  - The next state is IDLE; counters are cleared and `pend` is cleared.
  - A byte in flight returns the next cycle and is ignored.
  - No `fill_we` is issued for the abandoned refill.
- **Flush in WRITE.** The write still completes, since the data is correct for `base`; the state then returns to IDLE.
- **Flush together with `miss_valid` in IDLE.** The flush wins and the request is not accepted.
- **Address arithmetic.** Computed modulo 2^ADDR_W. `base` is 4-aligned, so bytes +0..+3 never cross a word, including at 0xFFFFFFFC.
- **`miss_addr` changes after acceptance.** Ignored until the next IDLE.

## Timing
- **Reset values (while `rst` is low):**
  - state = IDLE.
  - `miss_ready`, `mem_req`, `fill_we` = 0.
  - `mem_a`, `fill_addr`, `fill_inst` = 0.
  - `issued`, `recvd`, `pend` = 0.
- **Reset mid-refill.** Returns to IDLE immediately and produces no fill. The first acceptance is possible in the first cycle after `rst` rises.
- **Latency with continuous grant:**
  - Accept in cycle 0.
  - Issues in cycles 1–4.
  - Captures at the ends of cycles 2–5.
  - `fill_we` in cycle 6.
  - `miss_ready` high in cycle 7.
- Each cycle without grant adds exactly one cycle.
- `fill_addr` and `fill_inst` hold their values after WRITE until the next capture.
- `mem_req` and `mem_a` are combinational from registered state. `miss_ready` is combinational from state and `rst`.

## Structure
- `defines.v` additions:
  - State encodings `IRefIdle`, `IRefRead`, `IRefWrite`.
  - `RstnEnable` = 1'b0.
- `defines.v` reuse: existing `InstBus`, `InstAddrBus` and `ZeroWord`.
- Single module with no sub-module. Byte-lane assembly is a 4-way write-enable decode on `recvd`.
- The top level connects `fill_we` to the cache `we` and `fill_inst` to the cache `inst_i`. While `fill_we` is high, the cache address input is muxed to `fill_addr`.

## Test plan
- **Basic refill.**
  - Stimulus: `miss_addr` = 0x00001006, continuous grant, RAM bytes at 0x1004..0x1007 = 0x13,0x05,0x10,0x00.
  - Required: `mem_a` = 0x1004..0x1007 in cycles 1–4; in cycle 6 `fill_we` = 1, `fill_addr` = 0x00001004, `fill_inst` = 0x00100513.
- **Grant gaps.**
  - Stimulus: same request, `mem_gnt` low in cycles 2 and 3.
  - Required: the byte issued in cycle 1 is captured at the end of cycle 2; `fill_we` arrives in cycle 8 with the same `fill_inst`; exactly 4 issues occur.
- **Flush mid-read.**
  - Stimulus: `flush` in cycle 3.
  - Required: IDLE and `miss_ready` = 1 in cycle 4; no `fill_we` ever; a new miss to 0x2000 accepted in cycle 4 fills with only 0x2000 data.
- **Flush in WRITE and flush on accept.**
  - Stimulus: `flush` in cycle 6 of a refill; separately, `flush` and `miss_valid` together in IDLE.
  - Required: `fill_we` is still pulsed in cycle 6; the simultaneous request is not accepted and `mem_req` stays 0.
- **Async reset mid-refill.**
  - Stimulus: `rst` low asynchronously in cycle 4 of a refill.
  - Required: all outputs 0 immediately; no fill after release; a new request is accepted in the first cycle after release.
- **Address wrap.**
  - Stimulus: `miss_addr` = 0xFFFFFFFD.
  - Required: `mem_a` = 0xFFFFFFFC..0xFFFFFFFF and `fill_addr` = 0xFFFFFFFC.
